la_rstseq: RTL
==============

LA_RSTSEQ -- requirements
Module: la_rstseq

Interface
REQ-001 Parameter PROP, default "DEFAULT", implementation property string passed to sub-modules.
REQ-002 Parameter N, default 4, number of downstream reset domains, legal range 1..16.
REQ-003 Parameter HOLD, default 16, cycles all domain resets stay asserted, legal range 2..65535.
REQ-004 Parameter STAGES, default 2, synchronizer depth for ack inputs, legal range >= 2.
REQ-005 Parameter TIMEOUT, default 255, cycles to wait for each ack, legal range 1..65535.
REQ-006 clk  input  1  clock.
REQ-007 nrst_in  input  1  reset, asynchronous, active-low; deassertion is synchronous to clk, guaranteed upstream.
REQ-008 req  input  1  synchronous software reset request; a rising edge is detected internally.
REQ-009 ack  input  N  per-domain "reset released" indications, asynchronous to clk.
REQ-010 nrst_out  output  N  per-domain active-low resets, one bit per domain.
REQ-011 busy  output  1  sequence in progress.
REQ-012 done  output  1  all domains released.
REQ-013 err  output  1  sticky ack timeout flag.

Function
REQ-014 FSM states SHALL be ASSERT, RELEASE, WAIT, DONE.
REQ-015 In ASSERT, all nrst_out SHALL be 0 and a hold counter SHALL count clk edges; nrst_out[0] SHALL rise on the HOLD-th rising edge after nrst_in deassertion or after re-entry into ASSERT.
REQ-016 RELEASE SHALL drive nrst_out[i] high for domain index i, then enter WAIT.
REQ-017 WAIT SHALL monitor synchronized ack[i] (STAGES-flop latency); nrst_out[i+1] SHALL rise on the edge after synced ack[i] is first sampled high.
REQ-018 Released domains SHALL stay released; nrst_out SHALL never deassert out of index order.
REQ-019 After synced ack[N-1] is sampled high, the next edge SHALL enter DONE, set done=1 and set busy=0.
REQ-020 busy SHALL be 1 in ASSERT, RELEASE and WAIT; done SHALL be 1 only in DONE.
REQ-021 A req rising edge in DONE SHALL, at the next edge, drive all nrst_out low, clear done and err, set busy=1, clear the hold counter and enter ASSERT.
REQ-022 A req edge while busy=1 SHALL be ignored; req held high SHALL count as one edge.
REQ-023 An ack[i] falling in DONE SHALL have no effect.
REQ-024 Hold and timeout counters SHALL saturate and never wrap.
REQ-025 N=1 SHALL go ASSERT -> RELEASE -> WAIT -> DONE.

Reset
REQ-026 nrst_in low SHALL immediately and asynchronously force nrst_out=0, busy=1, done=0, err=0, state ASSERT, counters 0 and ack synchronizers 0, including mid-sequence.
REQ-027 All flops SHALL use asynchronous reset on nrst_in.

Configuration
REQ-028 With LA_RSTSEQ_TIMEOUT_EN defined, WAIT SHALL count cycles from the rise of nrst_out[i].
REQ-029 With LA_RSTSEQ_TIMEOUT_EN defined, if synced ack[i] is not high within TIMEOUT cycles, err SHALL set and stay set, and the sequence SHALL advance as if ack[i] had arrived.
REQ-030 Without LA_RSTSEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, err SHALL be tied 0 and no timeout counter SHALL exist.

Structure
REQ-031 Package la_rstseq_pkg SHALL hold the state enum typedef, the counter width constant (16) and the domain index width function.
REQ-032 Sub-module la_dsync (STAGES-deep per-bit synchronizer, PROP passed through) SHALL synchronize ack; it SHALL be instantiated once, N bits wide.
REQ-033 Outputs nrst_out, busy, done and err SHALL be driven directly from flops with no combinational path from inputs.

Verification (N=4, HOLD=16, STAGES=2, TIMEOUT=32, ack[i] = nrst_out[i] delayed 3 cycles unless stated)
REQ-034 Release nrst_in at edge 0 -> nrst_out[0] rises at edge 16, each later bit follows at synced-ack latency, done=1 and busy=0 after the ack[3] sync latency.
REQ-035 Drop nrst_in low at edge 20 -> nrst_out=0, busy=1 and done=0 asynchronously; release -> full sequence restarts with a 16-cycle hold.
REQ-036 Pulse req for 1 cycle in DONE -> next edge nrst_out=4'b0000, done=0, busy=1; resequence identical to REQ-034; a req pulse during busy -> no effect.
REQ-037 With LA_RSTSEQ_TIMEOUT_EN, tie ack[2]=0 -> err=1 32 cycles after nrst_out[2] rises, nrst_out[3] rises next, done=1; err clears on the next req.
REQ-038 Without LA_RSTSEQ_TIMEOUT_EN, tie ack[2]=0 -> busy stays 1, nrst_out=4'b0111 for 1000 cycles, err=0.
REQ-039 Hold req high for 100 cycles starting in DONE -> exactly one resequence occurs.

Source files
------------

// File: rtl/la_rstseq_pkg.sv
// la_rstseq_pkg: shared types and helpers for the la_rstseq reset sequencer.
// Holds the sequencer state encoding, the fixed counter width and small
// helper functions used by the top level.
package la_rstseq_pkg;

  // Sequencer states: hold all domains in reset, release one domain,
  // wait for its acknowledge, all domains released.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    WAIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Width of the hold and timeout counters; wide enough for 65535 cycles.
  localparam int CNT_W = 16;

  // Width needed to index n domains (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/la_dsync.sv
// la_dsync: STAGES-deep, W-bit wide flop synchronizer for asynchronous
// level inputs. Each bit is synchronized independently; all stages clear
// asynchronously on nrst_in. PROP is an implementation hint for libraries
// that map this cell to a dedicated synchronizer primitive.
module la_dsync #(
  parameter     PROP   = "DEFAULT",
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         nrst_in,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (STAGES < 2) begin : g_stages_chk
    $error("la_dsync: STAGES must be >= 2");
  end

  logic [W-1:0] sync_q [STAGES];

  // Shift each input bit through the synchronizer chain.
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      // NOTE: this array is reset explicitly (unlike a RAM) because its
      // contents are live state the sequencer acts on right after reset.
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/la_rstseq.sv
// la_rstseq: ordered reset release sequencer for N downstream domains.
// After nrst_in deasserts (or a software req edge while done), all domain
// resets are held for HOLD cycles, then released one at a time in index
// order, each waiting for the synchronized ack of the previous domain.
// Optional build macro LA_RSTSEQ_TIMEOUT_EN adds a per-domain ack timeout:
// a missing ack sets the sticky err flag and the sequence moves on.
module la_rstseq
  import la_rstseq_pkg::*;
#(
  parameter     PROP    = "DEFAULT",
  parameter int N       = 4,
  parameter int HOLD    = 16,
  parameter int STAGES  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         nrst_in,
  input  logic         req,
  input  logic [N-1:0] ack,
  output logic [N-1:0] nrst_out,
  output logic         busy,
  output logic         done,
  output logic         err
);

  if (N < 1 || N > 16) begin : g_n_chk
    $error("la_rstseq: N must be in 1..16");
  end
  if (HOLD < 2 || HOLD > 65535) begin : g_hold_chk
    $error("la_rstseq: HOLD must be in 2..65535");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_to_chk
    $error("la_rstseq: TIMEOUT must be in 1..65535");
  end

  localparam int                IDX_W     = idx_width(N);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
  // ASSERT spends HOLD-1 edges counting, RELEASE takes the HOLD-th edge.
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [N-1:0]     nrst_q, nrst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q;
  logic             req_rise;
  logic             adv;
  logic [N-1:0]     ack_sync;

`ifdef LA_RSTSEQ_TIMEOUT_EN
  // Counted from the edge that raised nrst_out[idx]; TIMEOUT-1 means expired.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] to_q, to_d;
  logic             err_q, err_d;
`endif

  la_dsync #(
    .PROP   (PROP),
    .STAGES (STAGES),
    .W      (N)
  ) u_ack_sync (
    .clk     (clk),
    .nrst_in (nrst_in),
    .din     (ack),
    .dout    (ack_sync)
  );

  assign req_rise = req & ~req_q;
  assign idx_nxt  = idx_q + 1'b1;

  // Next-state and next-output logic for the release sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    nrst_d  = nrst_q;
    busy_d  = busy_q;
    done_d  = done_q;
    adv     = 1'b0;
`ifdef LA_RSTSEQ_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      ASSERT: begin
        nrst_d = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
        if (hold_q >= HOLD_LAST) state_d = RELEASE;
        else                     hold_d  = sat_inc(hold_q);
      end

      RELEASE: begin
        nrst_d[idx_q] = 1'b1;
        state_d       = WAIT;
`ifdef LA_RSTSEQ_TIMEOUT_EN
        to_d          = '0;
`endif
      end

      WAIT: begin
`ifdef LA_RSTSEQ_TIMEOUT_EN
        if (ack_sync[idx_q]) begin
          adv = 1'b1;
        end else if (to_q >= TO_LAST) begin
          adv   = 1'b1;
          err_d = 1'b1;
        end else begin
          to_d = sat_inc(to_q);
        end
`else
        adv = ack_sync[idx_q];
`endif
        if (adv) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d           = idx_nxt;
            nrst_d[idx_nxt] = 1'b1;
`ifdef LA_RSTSEQ_TIMEOUT_EN
            to_d            = '0;
`endif
          end
        end
      end

      DONE: begin
        // Acks are ignored here; only a fresh req edge restarts the sequence.
        if (req_rise) begin
          state_d = ASSERT;
          nrst_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          hold_d  = '0;
          idx_d   = '0;
`ifdef LA_RSTSEQ_TIMEOUT_EN
          to_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end

      default: begin
        state_d = ASSERT;
        nrst_d  = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        hold_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State, counter, output and req-edge registers, all cleared by nrst_in.
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= ASSERT;
      hold_q  <= '0;
      idx_q   <= '0;
      nrst_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      nrst_q  <= nrst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req;
    end
  end

`ifdef LA_RSTSEQ_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign nrst_out = nrst_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
